// File: rtl/axis_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : axis_if
// Brief   : Minimal AXI-Stream bundle (tvalid/tready/tdata).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface axis_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_i2c_cmd_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : axis_i2c_cmd_queue
// Brief   : Queued I2C command issue onto AXI-Stream, with post-beat bus gap
//           and read-response capture with timeout.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module axis_i2c_cmd_queue #(
  parameter int I2C_DATA_WIDTH  = 8,
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int GAP_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [I2C_DATA_WIDTH-1:0]     cmd_addr_i,
  input  logic [I2C_DATA_WIDTH-1:0]     cmd_data_i,
  axis_if.master                        m_axis,
  input  logic [I2C_DATA_WIDTH-1:0]     rdata_i,
  input  logic                          rvalid_i,
  output logic                          rsp_valid_o,
  output logic [I2C_DATA_WIDTH-1:0]     rsp_data_o,
  output logic                          rsp_timeout_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  // GAP spans exactly GAP_CYCLES cycles, so the counter starts one short
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_TO_W-1:0]  c_TO_LOAD  = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [AXIS_DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]           r_wr_ptr;
  logic [c_PTR_W-1:0]           r_rd_ptr;
  logic [c_PTR_W:0]             r_level;

  logic                         r_tvalid;
  logic [AXIS_DATA_WIDTH-1:0]   r_tdata;
  logic [c_GAP_W-1:0]           r_gap_cnt;
  logic [c_TO_W-1:0]            r_to_cnt;

  logic                         r_rsp_valid;
  logic [I2C_DATA_WIDTH-1:0]    r_rsp_data;
  logic                         r_rsp_timeout;

  logic                         w_push;
  logic                         w_pop;
  logic                         w_hs;
  logic                         w_rw;
  logic                         w_gap_load;
  logic                         w_to_load;
  logic                         w_rsp_data;
  logic                         w_rsp_to;

  assign cmd_ready_o   = (r_level != c_FULL);
  assign level_o       = r_level;
  assign busy_o        = (r_state != S_IDLE) || (r_level != '0);
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_timeout_o = r_rsp_timeout;

  assign w_push = cmd_valid_i && cmd_ready_o;
  assign w_hs   = r_tvalid && m_axis.tready;
  assign w_rw   = r_tdata[0];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_gap_load  = 1'b0;
    w_to_load   = 1'b0;
    w_rsp_data  = 1'b0;
    w_rsp_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (GAP_CYCLES > 0) begin
            w_gap_load  = 1'b1;
            w_state_nxt = S_GAP;
          end else if (w_rw) begin
            w_to_load   = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (w_rw) begin
            w_to_load   = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        // data arriving on the expiry cycle takes priority over the timeout
        if (rvalid_i) begin
          w_rsp_data  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == '0) begin
          w_rsp_to    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_data_i, cmd_addr_i};
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_tdata  <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      if (w_pop) begin
        r_tvalid <= 1'b1;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
      end

      if (w_gap_load) begin
        r_gap_cnt <= c_GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end

      if (w_to_load) begin
        r_to_cnt <= c_TO_LOAD;
      end else if ((r_state == S_WAIT) && (r_to_cnt != '0)) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end

      r_rsp_valid <= w_rsp_data || w_rsp_to;
      if (w_rsp_data) begin
        r_rsp_data    <= rdata_i;
        r_rsp_timeout <= 1'b0;
      end else if (w_rsp_to) begin
        r_rsp_data    <= '0;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_cmd_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_axis_i2c_cmd_queue
// Brief   : Directed vector bench for axis_i2c_cmd_queue.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_axis_i2c_cmd_queue;

  localparam int W     = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 1024;

  logic       clk = 1'b0;
  logic       arstn_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [W-1:0] cmd_addr_i;
  logic [W-1:0] cmd_data_i;
  logic [W-1:0] rdata_i;
  logic       rvalid_i;
  logic       rsp_valid_o;
  logic [W-1:0] rsp_data_o;
  logic       rsp_timeout_o;
  logic       busy_o;
  logic [3:0] level_o;

  axis_if #(.DATA_WIDTH(AW)) u_axis ();

  always #5 clk = ~clk;

  axis_i2c_cmd_queue #(
    .I2C_DATA_WIDTH (W),
    .AXIS_DATA_WIDTH(AW),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk),
    .arstn_i      (arstn_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .m_axis       (u_axis),
    .rdata_i      (rdata_i),
    .rvalid_i     (rvalid_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_tdata;
  } vec_t;

  vec_t vecs [5];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    cmd_addr_i  = a;
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check({tag, "_tvalid"}, u_axis.tvalid, 0);
    check({tag, "_tdata"}, u_axis.tdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rsp_data"}, rsp_data_o, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_level"}, level_o, 0);
  endtask

  task automatic wait_hs(input string name);
    int k;
    k = 0;
    while (!(u_axis.tvalid && u_axis.tready) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check({name, "_hs_timeout"}, u_axis.tvalid, 1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy_o && k < 200) begin
      tick();
      k++;
    end
    check({name, "_idle"}, busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int stall_bad;
    int got;
    int last;
    int cyc;
    int quiet;
    int k;
    logic [7:0]  ea;
    logic [7:0]  ed;

    vecs[0] = '{8'h50, 8'hA5, 16'hA550};
    vecs[1] = '{8'h7E, 8'h00, 16'h007E};
    vecs[2] = '{8'h00, 8'hFF, 16'hFF00};
    vecs[3] = '{8'hAA, 8'h55, 16'h55AA};
    vecs[4] = '{8'hFE, 8'h01, 16'h01FE};

    arstn_i       = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_addr_i    = '0;
    cmd_data_i    = '0;
    rdata_i       = '0;
    rvalid_i      = 1'b0;
    u_axis.tready = 1'b1;
    tick();
    tick();
    check_reset("rst");
    arstn_i = 1'b1;
    tick();

    // single write beats: latency, single-cycle beat, busy drop after gap
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].addr, vecs[i].data);
      check("wr_level1", level_o, 1);
      check("wr_tvalid_n1", u_axis.tvalid, 0);
      tick();
      check("wr_tvalid", u_axis.tvalid, 1);
      check("wr_tdata", u_axis.tdata, 32'(vecs[i].exp_tdata));
      tick();
      check("wr_single_beat", u_axis.tvalid, 0);
      tick(); tick(); tick();
      check("wr_busy_gap", busy_o, 1);
      tick();
      check("wr_busy_done", busy_o, 0);
    end

    // fill beyond depth while stalled
    u_axis.tready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cmd_addr_i  = 8'h20 + 8'(2 * i);
      cmd_data_i  = 8'hC0 + 8'(i);
      cmd_valid_i = 1'b1;
      check("fill_ready", cmd_ready_o, 1);
      tick();
    end
    check("full_ready", cmd_ready_o, 0);
    check("full_level", level_o, DEPTH);
    cmd_addr_i = 8'hEE;
    cmd_data_i = 8'hEE;
    tick();
    cmd_valid_i = 1'b0;
    check("full_reject_level", level_o, DEPTH);

    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (u_axis.tvalid !== 1'b1 || u_axis.tdata !== 16'hC020) stall_bad++;
      tick();
    end
    check("stall_stable", stall_bad, 0);

    u_axis.tready = 1'b1;
    got  = 0;
    last = 0;
    cyc  = 0;
    while (got < DEPTH + 1 && cyc < 300) begin
      if (u_axis.tvalid && u_axis.tready) begin
        ea = 8'h20 + 8'(2 * got);
        ed = 8'hC0 + 8'(got);
        check("drain_tdata", u_axis.tdata, {16'h0, ed, ea});
        if (got > 0) check("drain_spacing", cyc - last, GAP + 2);
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    check("drain_count", got, DEPTH + 1);
    wait_idle("drain");

    // simultaneous push and pop at level 3
    u_axis.tready = 1'b0;
    push(8'h10, 8'h01);
    push(8'h12, 8'h02);
    push(8'h14, 8'h03);
    push(8'h16, 8'h04);
    check("pp_level_pre", level_o, 3);
    u_axis.tready = 1'b1;
    tick();
    tick(); tick(); tick();
    tick();
    check("pp_level_idle", level_o, 3);
    push(8'h18, 8'h05);
    check("pp_level_post", level_o, 3);
    check("pp_tdata", u_axis.tdata, 32'h0212);
    wait_idle("pp");

    // read with data 20 cycles after the handshake
    push(8'h51, 8'h00);
    wait_hs("rd");
    tick();
    quiet = 0;
    for (int i = 0; i < 19; i++) begin
      quiet += int'(rsp_valid_o);
      tick();
    end
    check("rd_quiet", quiet, 0);
    rvalid_i = 1'b1;
    rdata_i  = 8'h3C;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = 8'h00;
    check("rd_rsp_valid", rsp_valid_o, 1);
    check("rd_rsp_data", rsp_data_o, 8'h3C);
    check("rd_rsp_timeout", rsp_timeout_o, 0);
    tick();
    check("rd_rsp_pulse", rsp_valid_o, 0);
    check("rd_busy", busy_o, 0);

    // read timeout
    push(8'h53, 8'h99);
    wait_hs("to");
    k = 0;
    while (!rsp_valid_o && k < 1200) begin
      tick();
      k++;
    end
    check("to_latency", k, GAP + TMO + 2);
    check("to_rsp_data", rsp_data_o, 0);
    check("to_rsp_timeout", rsp_timeout_o, 1);
    tick();
    check("to_rsp_pulse", rsp_valid_o, 0);

    // stray read strobe while idle
    tick();
    rvalid_i = 1'b1;
    rdata_i  = 8'h77;
    tick();
    rvalid_i = 1'b0;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      quiet += int'(rsp_valid_o);
      tick();
    end
    check("stray_rvalid", quiet, 0);

    // reset while waiting for read data with 4 queued
    push(8'h61, 8'h00);
    wait_hs("rst_rd");
    for (int i = 0; i < 10; i++) tick();
    push(8'h30, 8'h01);
    push(8'h32, 8'h02);
    push(8'h34, 8'h03);
    push(8'h36, 8'h04);
    check("mid_level", level_o, 4);
    check("mid_busy", busy_o, 1);
    arstn_i = 1'b0;
    #1;
    check_reset("async_rst");
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet += int'(rsp_valid_o);
    end
    arstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet += int'(rsp_valid_o);
    end
    check("rst_no_rsp", quiet, 0);
    check("post_rst_level", level_o, 0);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_tvalid", u_axis.tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
